instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_if.sv | 38 +++
 rtl/instr_fetch_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for instr_fetch_unit: program loading, control and the
// instruction presentation handshake.
//
// Handshake: a word is transferred on every rising clock edge where
// instr_valid and instr_ready are both high. While instr_valid is high and
// instr_ready is low, instr, pc and instr_valid hold stable. instr_valid
// never depends combinationally on instr_ready.
interface instr_fetch_unit_if #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic             load_en;
  logic [WIDTH-1:0] load_data;
  logic             clear;
  logic             start;
  logic [WIDTH-1:0] instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [AW-1:0]    pc;
  logic [AW:0]      count;
  logic             busy;
  logic             done;
  logic             overflow;

  // Host side: loads the program, controls the unit, consumes instructions.
  modport master (
    output load_en, load_data, clear, start, instr_ready,
    input  instr, instr_valid, pc, count, busy, done, overflow
  );

  // Fetch unit side.
  modport slave (
    input  load_en, load_data, clear, start, instr_ready,
    output instr, instr_valid, pc, count, busy, done, overflow
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a small program memory that is filled word by
// word in IDLE and then streamed out in order from address 0 in RUN.
// Each word goes through a synchronous read (READ), a registered capture
// (LATCH) and is then presented (SHOW) until the consumer accepts it, so a
// word becomes valid two clock edges after start or after the previous
// handshake. An all-zero word is a halt marker: it is never presented and
// ends the run.
module instr_fetch_unit #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.slave   bus_io,
  output logic [1:0]          state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Sub-phase of RUN: where the current word is in the read pipeline.
  typedef enum logic [1:0] {
    PH_READ  = 2'd0,
    PH_LATCH = 2'd1,
    PH_SHOW  = 2'd2
  } phase_e;

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             mem_we;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] mem [DEPTH];

  // Control registers; reset wins over every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_READ;
      pc_q       <= '0;
      count_q    <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Program memory: write port used only while loading in IDLE, read port
  // registered every cycle from pc (contents survive reset and clear).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[count_q[AW-1:0]] <= bus_io.load_data;
    end
    rdata_q <= mem[pc_q];
  end

  // Next-state logic: clear beats start/load_en, then per-state behaviour.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    pc_d       = pc_q;
    count_d    = count_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;

    if (bus_io.clear) begin
      state_d    = S_IDLE;
      phase_d    = PH_READ;
      pc_d       = '0;
      count_d    = '0;
      instr_d    = '0;
      valid_d    = 1'b0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus_io.load_en) begin
            if (count_q == DEPTH_C) begin
              overflow_d = 1'b1;
            end else begin
              mem_we  = 1'b1;
              count_d = count_q + CW'(1);
            end
          end
          // Uses count_d so a same-cycle load is part of the program.
          if (bus_io.start && (count_d != '0)) begin
            state_d = S_RUN;
            phase_d = PH_READ;
            pc_d    = '0;
          end
        end
        S_RUN: begin
          unique case (phase_q)
            PH_READ: begin
              phase_d = PH_LATCH;
            end
            PH_LATCH: begin
              if (rdata_q == '0) begin
                state_d = S_DONE;
              end else begin
                instr_d = rdata_q;
                valid_d = 1'b1;
                phase_d = PH_SHOW;
              end
            end
            PH_SHOW: begin
              if (bus_io.instr_ready) begin
                valid_d = 1'b0;
                if ({1'b0, pc_q} == count_q - CW'(1)) begin
                  state_d = S_DONE;
                end else begin
                  pc_d    = pc_q + AW'(1);
                  phase_d = PH_READ;
                end
              end
            end
            default: begin
              phase_d = PH_READ;
            end
          endcase
        end
        S_DONE: begin
          if (bus_io.start) begin
            state_d = S_RUN;
            phase_d = PH_READ;
            pc_d    = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus_io.instr       = instr_q;
  assign bus_io.instr_valid = valid_q;
  assign bus_io.pc          = pc_q;
  assign bus_io.count       = count_q;
  assign bus_io.busy        = (state_q == S_RUN);
  assign bus_io.done        = (state_q == S_DONE);
  assign bus_io.overflow    = overflow_q;
  assign state_o            = state_q;
endmodule
